// File: rtl/core_io_pkg.sv
// Shared command/response encodings and STATUS word layout for the core I/O mailbox.
package core_io_pkg;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_SEND   = 2'b01,
        CMD_RECV   = 2'b10,
        CMD_STATUS = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_ACK  = 2'b01,
        RSP_DATA = 2'b10,
        RSP_NACK = 2'b11
    } rsp_e;

    // STATUS word: occupancies in the low two bytes, sticky error flags above.
    localparam int ST_OCC_W      = 8;
    localparam int ST_TX_OCC_LSB = 0;
    localparam int ST_RX_OCC_LSB = 8;
    localparam int ST_TX_OVF_BIT = 16;
    localparam int ST_RX_UNF_BIT = 17;

endpackage

// File: rtl/core_io_mailbox_if.sv
// Core command/response port plus host-side TX/RX streams of the mailbox.
interface core_io_mailbox_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            to_peripheral;
    logic [DATA_WIDTH-1:0] to_peripheral_data;
    logic                  to_peripheral_valid;
    logic [1:0]            from_peripheral;
    logic [DATA_WIDTH-1:0] from_peripheral_data;
    logic                  from_peripheral_valid;
    logic [DATA_WIDTH-1:0] host_tx_data;
    logic                  host_tx_valid;
    logic                  host_tx_ready;
    logic [DATA_WIDTH-1:0] host_rx_data;
    logic                  host_rx_valid;
    logic                  host_rx_ready;

    // Agent side: the core issuing commands and the host moving words.
    modport master (
        output to_peripheral, to_peripheral_data, to_peripheral_valid,
        input  from_peripheral, from_peripheral_data, from_peripheral_valid,
        input  host_tx_data, host_tx_valid,
        output host_tx_ready,
        output host_rx_data, host_rx_valid,
        input  host_rx_ready
    );

    // Mailbox side.
    modport slave (
        input  to_peripheral, to_peripheral_data, to_peripheral_valid,
        output from_peripheral, from_peripheral_data, from_peripheral_valid,
        output host_tx_data, host_tx_valid,
        input  host_tx_ready,
        input  host_rx_data, host_rx_valid,
        output host_rx_ready
    );
endinterface

// File: rtl/core_io_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The caller gates push with !full and pop with !empty.
module core_io_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at power-of-two depth; count tracks push/pop balance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);

endmodule

// File: rtl/core_io_mailbox.sv
// Core I/O mailbox: decodes core commands, moves words through TX/RX FIFOs,
// keeps sticky overflow/underflow flags and registers a one-cycle response.
module core_io_mailbox
    import core_io_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    core_io_mailbox_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cmd_e                  cmd;
    logic                  cmd_send, cmd_recv, cmd_status;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]         tx_count, rx_count;
    logic [DATA_WIDTH-1:0] rx_head;
    logic [DATA_WIDTH-1:0] status_word;
    logic                  tx_overflow, rx_underflow, tx_overflow_d, rx_underflow_d;
    logic                  rx_ready_en;
    logic                  rsp_valid_q, rsp_valid_d;
    rsp_e                  rsp_code_q, rsp_code_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Command decode and FIFO strobes; full/empty are the pre-edge registered values.
    always_comb begin
        cmd        = cmd_e'(bus.to_peripheral);
        cmd_send   = bus.to_peripheral_valid && (cmd == CMD_SEND);
        cmd_recv   = bus.to_peripheral_valid && (cmd == CMD_RECV);
        cmd_status = bus.to_peripheral_valid && (cmd == CMD_STATUS);
        tx_push    = cmd_send && !tx_full;
        tx_pop     = bus.host_tx_ready && !tx_empty;
        rx_push    = bus.host_rx_valid && rx_ready_en && !rx_full;
        rx_pop     = cmd_recv && !rx_empty;
    end

    core_io_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus.to_peripheral_data),
        .pop       (tx_pop),
        .pop_data  (bus.host_tx_data),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    core_io_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus.host_rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Assemble STATUS word; a STATUS read clears the sticky flags before any new event sets them.
    always_comb begin
        status_word = '0;
        status_word[ST_TX_OCC_LSB +: ST_OCC_W] = ST_OCC_W'(tx_count);
        status_word[ST_RX_OCC_LSB +: ST_OCC_W] = ST_OCC_W'(rx_count);
        status_word[ST_TX_OVF_BIT]             = tx_overflow;
        status_word[ST_RX_UNF_BIT]             = rx_underflow;
        tx_overflow_d  = (tx_overflow  && !cmd_status) || (cmd_send && tx_full);
        rx_underflow_d = (rx_underflow && !cmd_status) || (cmd_recv && rx_empty);
    end

    // Response selection for the command sampled this cycle.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_code_d  = RSP_NONE;
        rsp_data_d  = '0;
        if (cmd_send) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = tx_full ? RSP_NACK : RSP_ACK;
        end else if (cmd_recv) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = rx_empty ? RSP_NACK : RSP_DATA;
            rsp_data_d  = rx_empty ? '0 : rx_head;
        end else if (cmd_status) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_DATA;
            rsp_data_d  = status_word;
        end
    end

    // Response register, sticky flags and RX-ready enable that rises one cycle after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= RSP_NONE;
            rsp_data_q   <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            rx_ready_en  <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
            rsp_data_q   <= rsp_data_d;
            tx_overflow  <= tx_overflow_d;
            rx_underflow <= rx_underflow_d;
            rx_ready_en  <= 1'b1;
        end
    end

    assign bus.from_peripheral       = rsp_code_q;
    assign bus.from_peripheral_data  = rsp_data_q;
    assign bus.from_peripheral_valid = rsp_valid_q;
    assign bus.host_tx_valid         = !tx_empty;
    assign bus.host_rx_ready         = rx_ready_en && !rx_full;

endmodule

// File: tb/tb_core_io_mailbox.sv
// Directed bench for core_io_mailbox with hand-computed expected responses.
module tb_core_io_mailbox;
    import core_io_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  r_code;
    logic [31:0] r_data;
    logic        r_valid;

    core_io_mailbox_if #(.DATA_WIDTH(32)) bus ();

    core_io_mailbox #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one command at the falling edge, capture the response just after the next rising edge.
    task automatic do_cmd(input logic [1:0] c, input logic [31:0] d);
        @(negedge clk);
        bus.to_peripheral       = c;
        bus.to_peripheral_data  = d;
        bus.to_peripheral_valid = 1'b1;
        @(posedge clk);
        #1;
        r_code  = bus.from_peripheral;
        r_data  = bus.from_peripheral_data;
        r_valid = bus.from_peripheral_valid;
    endtask

    task automatic expect_rsp(input string tag, input logic [1:0] code, input logic [31:0] data);
        check({tag, "_valid"}, {31'b0, r_valid}, 32'd1);
        check({tag, "_code"}, {30'b0, r_code}, {30'b0, code});
        check({tag, "_data"}, r_data, data);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.to_peripheral_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic host_push(input logic [31:0] d);
        @(negedge clk);
        bus.host_rx_valid = 1'b1;
        bus.host_rx_data  = d;
        @(negedge clk);
        bus.host_rx_valid = 1'b0;
    endtask

    initial begin
        bus.to_peripheral       = CMD_SEND;
        bus.to_peripheral_data  = 32'h77;
        bus.to_peripheral_valid = 1'b1;
        bus.host_tx_ready       = 1'b0;
        bus.host_rx_data        = '0;
        bus.host_rx_valid       = 1'b0;

        // Reset held with a SEND asserted: everything stays quiet.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, bus.from_peripheral_valid}, 32'd0);
        check("rst_rsp_code", {30'b0, bus.from_peripheral}, 32'd0);
        check("rst_rsp_data", bus.from_peripheral_data, 32'd0);
        check("rst_tx_valid", {31'b0, bus.host_tx_valid}, 32'd0);
        check("rst_rx_ready", {31'b0, bus.host_rx_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.to_peripheral_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_rx_ready", {31'b0, bus.host_rx_ready}, 32'd1);
        check("post_rst_tx_valid", {31'b0, bus.host_tx_valid}, 32'd0);

        // SEND fill and overflow.
        for (int i = 0; i < 8; i++) begin
            do_cmd(CMD_SEND, 32'h11 + i);
            expect_rsp($sformatf("send_%0d", i), RSP_ACK, 32'h0);
            if (i == 0) begin
                check("tx_valid_first", {31'b0, bus.host_tx_valid}, 32'd1);
                check("tx_data_first", bus.host_tx_data, 32'h11);
            end
        end
        do_cmd(CMD_SEND, 32'h19);
        expect_rsp("send_full", RSP_NACK, 32'h0);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_ovf", RSP_DATA, 32'h0001_0008);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_clr", RSP_DATA, 32'h0000_0008);
        idle(1);
        check("rsp_strobe_drops", {31'b0, bus.from_peripheral_valid}, 32'd0);

        // Drain order.
        bus.host_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'b0, bus.host_tx_valid}, 32'd1);
            check($sformatf("drain_data_%0d", i), bus.host_tx_data, 32'h11 + i);
            @(negedge clk);
        end
        check("drain_empty", {31'b0, bus.host_tx_valid}, 32'd0);
        bus.host_tx_ready = 1'b0;

        // RECV on empty, then RX path.
        do_cmd(CMD_RECV, 32'h0);
        expect_rsp("recv_empty", RSP_NACK, 32'h0);
        idle(1);
        host_push(32'hDEAD_BEEF);
        do_cmd(CMD_RECV, 32'h0);
        expect_rsp("recv_word", RSP_DATA, 32'hDEAD_BEEF);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_unf", RSP_DATA, 32'h0002_0000);
        idle(1);

        // RX full: nine offers, only eight accepted.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.host_rx_valid = 1'b1;
            bus.host_rx_data  = 32'hA0 + i;
            check($sformatf("rx_ready_%0d", i), {31'b0, bus.host_rx_ready}, (i < 8) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.host_rx_valid = 1'b0;
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_rx_full", RSP_DATA, 32'h0000_0800);
        for (int i = 0; i < 8; i++) begin
            do_cmd(CMD_RECV, 32'h0);
            expect_rsp($sformatf("recv_%0d", i), RSP_DATA, 32'hA0 + i);
        end
        idle(1);
        check("rx_ready_after_drain", {31'b0, bus.host_rx_ready}, 32'd1);

        // Simultaneous events: SEND while full with a same-cycle host pop is still NACKed.
        for (int i = 0; i < 8; i++) begin
            do_cmd(CMD_SEND, 32'h21 + i);
            expect_rsp($sformatf("refill_%0d", i), RSP_ACK, 32'h0);
        end
        bus.host_tx_ready = 1'b1;
        do_cmd(CMD_SEND, 32'h29);
        bus.host_tx_ready = 1'b0;
        expect_rsp("send_full_pop", RSP_NACK, 32'h0);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_occ7", RSP_DATA, 32'h0001_0007);
        check("tx_head_after_pop", bus.host_tx_data, 32'h22);
        do_cmd(CMD_SEND, 32'h2A);
        expect_rsp("send_to_full", RSP_ACK, 32'h0);
        do_cmd(CMD_SEND, 32'h2B);
        expect_rsp("send_over", RSP_NACK, 32'h0);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_b2b", RSP_DATA, 32'h0001_0008);
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_b2b_clr", RSP_DATA, 32'h0000_0008);

        // Reset mid-stream with stickies set and TX full.
        do_cmd(CMD_RECV, 32'h0);
        expect_rsp("recv_empty2", RSP_NACK, 32'h0);
        @(negedge clk);
        bus.to_peripheral      = CMD_SEND;
        bus.to_peripheral_data = 32'h5;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rsp_valid", {31'b0, bus.from_peripheral_valid}, 32'd0);
        check("midrst_tx_valid", {31'b0, bus.host_tx_valid}, 32'd0);
        check("midrst_rx_ready", {31'b0, bus.host_rx_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.to_peripheral_valid = 1'b0;
        do_cmd(CMD_STATUS, 32'h0);
        expect_rsp("status_after_rst", RSP_DATA, 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_io_mailbox.md
# core_io_mailbox

Peripheral endpoint attached directly to the core's `to_peripheral*` / `from_peripheral*` I/O ports. It carries 32-bit words between the running program and a host/testbench agent through two FIFOs:
- TX: core to host.
- RX: host to core.

It answers every core command with a registered response. Benches use it to stream results, such as pass/fail signatures, out of the core, and to feed input data into programs.

## Interface
Parameters:
- DATA_WIDTH, 32, word width on all data paths.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
- clock  in  1  single clock domain, rising edge.
- reset  in  1  synchronous, active-low.
- to_peripheral  in  2  core command: 00 NOP, 01 SEND, 10 RECV, 11 STATUS.
- to_peripheral_data  in  DATA_WIDTH  SEND payload; ignored for other commands.
- to_peripheral_valid  in  1  command qualifier; command field ignored when low.
- from_peripheral  out  2  response code: 00 NONE, 01 ACK, 10 DATA, 11 NACK.
- from_peripheral_data  out  DATA_WIDTH  response payload.
- from_peripheral_valid  out  1  one-cycle response strobe.
- host_tx_data  out  DATA_WIDTH  TX FIFO head (first-word-fall-through).
- host_tx_valid  out  1  TX FIFO not empty.
- host_tx_ready  in  1  host pops TX head when valid & ready.
- host_rx_data  in  DATA_WIDTH  word from host.
- host_rx_valid  in  1  host offers word.
- host_rx_ready  out  1  RX FIFO not full.

## Operation
- **SEND**
  - TX not full: push payload, respond ACK with data 0.
  - TX full: drop payload, respond NACK with data 0, set sticky tx_overflow.
- **RECV**
  - RX not empty: pop head, respond DATA with the popped word.
  - RX empty: respond NACK with data 0, set sticky rx_underflow.
- **STATUS**: respond DATA with the following word:
  - [7:0] TX occupancy.
  - [15:8] RX occupancy.
  - [16] tx_overflow.
  - [17] rx_underflow.
  - remaining bits 0.
  - Both sticky bits clear on the same edge.
- **NOP**, or valid low: no response; from_peripheral_valid stays 0.
- **Full/empty decisions** use occupancy registered before the current edge:
  - SEND while TX full is NACKed even if the host pops TX in the same cycle.
  - RECV while RX empty is NACKed even if the host pushes RX in the same cycle.
- **Host side**:
  - A TX pop occurs when host_tx_valid & host_tx_ready.
  - An RX push occurs when host_rx_valid & host_rx_ready.
  - Each FIFO supports a simultaneous push and pop; occupancy is unchanged.
- **Sticky bits**: if an overflow/underflow event coincides with a STATUS read, the clear takes effect first and the new event sets the bit. That event is therefore reported by the next STATUS.
- **Pointers** wrap modulo FIFO_DEPTH. Occupancy counters are $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Response latency is exactly 1 cycle: a command sampled at edge N yields from_peripheral* valid for the cycle after edge N, then valid returns to 0 unless a new command was issued.
- Back-to-back commands are accepted every cycle with no stall; responses stream one per cycle in command order.
- A SEND ACKed at edge N makes host_tx_valid high after edge N, with host_tx_data equal to the payload if TX was empty.
- A host RX push at edge N is visible to a RECV sampled at edge N+1 or later.
- **Reset (reset=0 at an edge)**:
  - Both FIFOs flush; occupancy goes to 0.
  - Sticky bits go to 0.
  - Any response due next cycle is dropped.
  - Outputs: from_peripheral=00, from_peripheral_data=0, from_peripheral_valid=0, host_tx_valid=0, host_rx_ready=0 while reset is held.
  - host_rx_ready rises the cycle after reset deasserts.
  - Commands are ignored while reset is 0.

## Structure
- Shared package core_io_pkg holds:
  - command codes (CMD_NOP/SEND/RECV/STATUS);
  - response codes (RSP_NONE/ACK/DATA/NACK);
  - STATUS field positions.
- Sub-module core_io_fifo (synchronous FWFT FIFO, parameterised by DATA_WIDTH/FIFO_DEPTH, exposes occupancy) is instantiated twice.
- The top level contains command decode, sticky flags and the response register.

## Test plan
- **SEND fill and overflow.** Reset, then SEND 0x11..0x18 on 8 consecutive cycles, then SEND 0x19.
  - Expect 8 ACKs, then NACK.
  - STATUS returns 0x0001_0008.
  - A second STATUS returns 0x0000_0008.
- **Drain order.** Host drains TX with ready=1.
  - host_tx_data sequence is 0x11..0x18.
  - host_tx_valid drops after the 8th pop.
- **RECV on empty, then RX path.** RECV on empty RX gives NACK and sets rx_underflow. Host then pushes 0xDEADBEEF.
  - RECV returns DATA 0xDEADBEEF.
  - STATUS returns 0x0002_0000.
- **RX full.** Host pushes 9 words.
  - host_rx_ready is low after 8 pushes.
  - 8 RECVs return the words in order.
- **Simultaneous events.**
  - TX full with a host pop in the same cycle as SEND: NACK, occupancy 7 afterwards.
  - SEND-to-full in the same cycle as STATUS: tx_overflow remains set afterwards.
- **Reset mid-stream.** Issue SEND 0x5 and assert reset at the next edge.
  - No response strobe.
  - host_tx_valid=0.
  - STATUS after reset returns 0.
